mixsx32_serializer: RTL and testbench
=====================================

Name: mixsx32_serializer

Overview:
- Downstream stage of the mixsx32 mixing block.
- Captures the full CWORDS64*64-bit mixed result when the upstream ready level rises, and holds it in a local buffer.
- Streams the buffer out as 64-bit words, least-significant word first, over a valid/ready handshake to the next consumer (hash/absorb or output FIFO).
- Flags results that arrive while a previous result is still being drained.

Parameters:
- CWORDS64, 2, number of 64-bit words per result; must be >= 1.
- IDX_W, (CWORDS64>1 ? $clog2(CWORDS64) : 1), width of the word index; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- cin  input  CWORDS64*64  mixed result from the upstream mixer (its cout).
- data_rdy_in  input  1  upstream result-ready level (its data_rdy); held high once the result is valid.
- out_data  output  64  current word = buf[out_idx*64 +: 64].
- out_valid  output  1  out_data holds a word not yet accepted.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- out_idx  output  IDX_W  index of the word on out_data.
- out_last  output  1  out_valid && out_idx == CWORDS64-1.
- busy  output  1  high in SEND.
- overrun  output  1  sticky: a result edge was dropped.

Behaviour:
- Reset (reset==0, asynchronous, takes effect immediately, including mid-transfer):
  - state=IDLE, buf=0, out_idx=0, out_valid=0, out_data=0, busy=0, overrun=0, rdy_q=0.
  - The transfer in progress is abandoned. There is no partial resume.
- Edge detect:
  - rdy_q registers data_rdy_in every cycle.
  - rise = data_rdy_in && !rdy_q.
  - A level already high on the first cycle after reset release counts as a rise.
- FSM with states IDLE and SEND.
  - IDLE, rise: buf<=cin, out_idx<=0, go to SEND. out_valid=1 on the next cycle, so latency is 1 clk from the rising edge.
  - IDLE, no rise: stay in IDLE, out_valid=0.
  - SEND, fire (out_valid && out_ready) with out_idx<CWORDS64-1: out_idx<=out_idx+1, stay in SEND. The next word is presented the following cycle, giving 1 word/clk at full throughput.
  - SEND, fire with out_idx==CWORDS64-1, no rise: go to IDLE. out_valid=0 the next cycle and out_idx<=0.
  - SEND, fire on the last word and rise in the same cycle: back-to-back accept. buf<=cin, out_idx<=0, stay in SEND, no bubble, overrun unchanged.
  - SEND, rise without a last-word fire: the new result is dropped, buf is unchanged, and overrun<=1 (sticky until reset).
  - SEND, out_ready=0: out_data, out_idx and out_last are held stable. out_valid never drops without a fire.
- out_data and out_last are combinational from buf and out_idx, gated to 0 when out_valid=0.
- CWORDS64=1:
  - Every word is the last word.
  - out_idx is a constant 0.
  - The FSM goes IDLE→SEND→IDLE per result.
- No arithmetic on the data. Words are passed bit-exact, word k = cin[k*64 +: 64].

Test Plan (CWORDS64=2 unless noted):
- Basic drain:
  - Stimulus: cin={64'h2222_2222_0000_00BB, 64'h1111_1111_0000_00AA}, data_rdy_in 0→1, out_ready=1.
  - Required response: next cycle out_valid=1, out_data=64'h1111_1111_0000_00AA, out_idx=0, out_last=0. Following cycle out_data=64'h2222_2222_0000_00BB, out_last=1. Then out_valid=0, busy=0.
- Backpressure:
  - Stimulus: same load, out_ready=0 for 5 cycles, then 1.
  - Required response: out_data=64'h1111_1111_0000_00AA and out_valid=1 held all 5 cycles, then both words delivered in order.
- Overrun:
  - Stimulus: during SEND with out_ready=0, pulse data_rdy_in 0→1→0→1 with cin changed to all-ones.
  - Required response: overrun=1 and stays 1. The buffer still delivers the original two words. The all-ones value never appears.
- Back-to-back:
  - Stimulus: data_rdy_in rises in the same cycle as the last-word fire, with new cin={64'h4, 64'h3}.
  - Required response: next cycle out_data=64'h3, out_idx=0, out_valid=1 with no gap, overrun=0.
- Reset mid-transfer:
  - Stimulus: drive reset=0 asynchronously between clock edges after word 0 is accepted.
  - Required response: out_valid, busy, out_data and overrun go to 0 immediately. After release with data_rdy_in still high, a fresh capture starts and word 0 is re-sent.
- CWORDS64=1:
  - Stimulus: cin=64'hDEAD_BEEF_0123_4567, data_rdy_in rise, out_ready=1.
  - Required response: one beat with out_last=1 and out_idx=0, then IDLE.

Source files
------------

// File: rtl/mixsx32_serializer.sv
// Captures a CWORDS64x64-bit mixed result on a rising ready level and streams
// it out LSW-first over a valid/ready handshake; flags results dropped mid-drain.
module mixsx32_serializer #(
    parameter int CWORDS64 = 2
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [CWORDS64*64-1:0]                     cin,
    input  logic                                       data_rdy_in,
    output logic [63:0]                                out_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [((CWORDS64 > 1) ? $clog2(CWORDS64) : 1)-1:0] out_idx,
    output logic                                       out_last,
    output logic                                       busy,
    output logic                                       overrun
);

    localparam int IDX_W = (CWORDS64 > 1) ? $clog2(CWORDS64) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CWORDS64 - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state;
    logic [CWORDS64*64-1:0] buf_q;
    logic                   rdy_q;
    logic                   rise;
    logic                   fire;
    logic                   at_last;
    logic [63:0]            words [CWORDS64];

    genvar k;
    for (k = 0; k < CWORDS64; k++) begin : g_word
        assign words[k] = buf_q[k*64 +: 64];
    end

    // rdy_q clears on reset, so a level already high at release reads as a rise
    assign rise    = data_rdy_in && !rdy_q;
    assign fire    = out_valid && out_ready;
    assign at_last = (out_idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            buf_q     <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            rdy_q <= data_rdy_in;
            case (state)
                IDLE: begin
                    if (rise) begin
                        buf_q     <= cin;
                        out_idx   <= '0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (fire && at_last) begin
                        out_idx <= '0;
                        if (rise) begin
                            // back-to-back result: reload with no bubble
                            buf_q <= cin;
                        end else begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end else begin
                        if (fire)
                            out_idx <= out_idx + IDX_W'(1);
                        if (rise)
                            overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_data = out_valid ? words[out_idx] : 64'd0;
    assign out_last = out_valid && at_last;

endmodule

// File: tb/tb_mixsx32_serializer.sv
// Scoreboard bench for mixsx32_serializer: a word-count model queues expected
// beats per accepted result; a negedge monitor pops and compares each fire.
module tb_mixsx32_serializer;

    localparam int N = 2;

    logic           clk;
    logic           reset;
    logic [N*64-1:0] cin;
    logic           data_rdy_in;
    logic [63:0]    out_data;
    logic           out_valid;
    logic           out_ready;
    logic [0:0]     out_idx;
    logic           out_last;
    logic           busy;
    logic           overrun;

    logic [63:0]    cin1;
    logic           rdy1;
    logic [63:0]    out_data1;
    logic           out_valid1;
    logic           out_ready1;
    logic [0:0]     out_idx1;
    logic           out_last1;
    logic           busy1;
    logic           overrun1;

    mixsx32_serializer #(.CWORDS64(N)) dut (
        .clk(clk), .reset(reset), .cin(cin), .data_rdy_in(data_rdy_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .overrun(overrun)
    );

    mixsx32_serializer #(.CWORDS64(1)) dut1 (
        .clk(clk), .reset(reset), .cin(cin1), .data_rdy_in(rdy1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_idx(out_idx1), .out_last(out_last1), .busy(busy1), .overrun(overrun1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [63:0] d;
        int          idx;
        bit          last;
    } beat_t;

    beat_t sb[$];
    int    cnt      = 0;
    bit    prev     = 1'b0;
    bit    exp_over = 1'b0;

    // Model and monitor: the model tracks only how many words of the current
    // result remain; every accepted result pushes all its words to sb.
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            cnt      = 0;
            prev     = 1'b0;
            exp_over = 1'b0;
        end else begin
            bit rise_m, fire_m;
            chk("valid", {63'd0, out_valid}, {63'd0, cnt > 0});
            chk("busy", {63'd0, busy}, {63'd0, cnt > 0});
            chk("overrun", {63'd0, overrun}, {63'd0, exp_over});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got beat %h expected none", out_data);
                end else begin
                    beat_t b;
                    b = sb.pop_front();
                    chk("data", out_data, b.d);
                    chk("idx", {63'd0, out_idx}, 64'(b.idx));
                    chk("last", {63'd0, out_last}, {63'd0, b.last});
                end
            end else if (!out_valid) begin
                chk("data_gated", out_data, 64'd0);
            end

            rise_m = data_rdy_in && !prev;
            fire_m = (cnt > 0) && out_ready;
            if (cnt == 0) begin
                if (rise_m) cnt = N;
            end else if (fire_m && cnt == 1) begin
                cnt = rise_m ? N : 0;
            end else begin
                if (fire_m) cnt--;
                if (rise_m) exp_over = 1'b1;
                rise_m = 1'b0;
            end
            if (rise_m) begin
                for (int k = 0; k < N; k++) begin
                    beat_t b;
                    b.d    = cin[k*64 +: 64];
                    b.idx  = k;
                    b.last = (k == N - 1);
                    sb.push_back(b);
                end
            end
            prev = data_rdy_in;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [N*64-1:0] A = {64'h2222_2222_0000_00BB, 64'h1111_1111_0000_00AA};

    initial begin
        reset = 1'b1; cin = '0; data_rdy_in = 1'b0; out_ready = 1'b1;
        cin1 = '0; rdy1 = 1'b0; out_ready1 = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_idx", {63'd0, out_idx}, 64'd0);
        chk("rst_last", {63'd0, out_last}, 64'd0);
        chk("rst_overrun", {63'd0, overrun}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        tick();

        // basic drain
        cin = A; data_rdy_in = 1'b1; tick();
        @(negedge clk);
        chk("basic_w0", out_data, 64'h1111_1111_0000_00AA);
        chk("basic_last0", {63'd0, out_last}, 64'd0);
        tick();
        @(negedge clk);
        chk("basic_w1", out_data, 64'h2222_2222_0000_00BB);
        chk("basic_last1", {63'd0, out_last}, 64'd1);
        tick();
        @(negedge clk);
        chk("basic_idle", {63'd0, out_valid}, 64'd0);
        data_rdy_in = 1'b0; tick();

        // backpressure
        out_ready = 1'b0; data_rdy_in = 1'b1; tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", out_data, 64'h1111_1111_0000_00AA);
            tick();
        end
        out_ready = 1'b1; tick(); tick(); tick();
        data_rdy_in = 1'b0; tick();

        // back-to-back
        data_rdy_in = 1'b1; tick();
        data_rdy_in = 1'b0; tick();
        cin = {64'h4, 64'h3}; data_rdy_in = 1'b1; tick();
        @(negedge clk);
        chk("b2b_w0", out_data, 64'h3);
        chk("b2b_valid", {63'd0, out_valid}, 64'd1);
        chk("b2b_over", {63'd0, overrun}, 64'd0);
        tick();
        data_rdy_in = 1'b0; tick(); tick();

        // overrun
        cin = A; data_rdy_in = 1'b1; out_ready = 1'b0; tick();
        data_rdy_in = 1'b0; tick();
        cin = '1; data_rdy_in = 1'b1; tick();
        data_rdy_in = 1'b0; tick();
        data_rdy_in = 1'b1; tick();
        @(negedge clk);
        chk("ovr_set", {63'd0, overrun}, 64'd1);
        out_ready = 1'b1; tick(); tick(); tick();
        data_rdy_in = 1'b0; tick();
        chk("ovr_sticky", {63'd0, overrun}, 64'd1);

        // reset mid-transfer
        cin = A; data_rdy_in = 1'b1; tick();
        tick();
        #2 reset = 1'b0;
        #1;
        chk("mrst_valid", {63'd0, out_valid}, 64'd0);
        chk("mrst_busy", {63'd0, busy}, 64'd0);
        chk("mrst_data", out_data, 64'd0);
        chk("mrst_over", {63'd0, overrun}, 64'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        tick();
        @(negedge clk);
        chk("mrst_resend", out_data, 64'h1111_1111_0000_00AA);
        tick(); tick();
        data_rdy_in = 1'b0; tick();

        // single-word instance
        cin1 = 64'hDEAD_BEEF_0123_4567; rdy1 = 1'b1; tick();
        @(negedge clk);
        chk("cw1_valid", {63'd0, out_valid1}, 64'd1);
        chk("cw1_data", out_data1, 64'hDEAD_BEEF_0123_4567);
        chk("cw1_last", {63'd0, out_last1}, 64'd1);
        chk("cw1_idx", {63'd0, out_idx1}, 64'd0);
        tick();
        @(negedge clk);
        chk("cw1_idle", {63'd0, out_valid1}, 64'd0);
        chk("cw1_busy", {63'd0, busy1}, 64'd0);
        rdy1 = 1'b0;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) data_rdy_in = ~data_rdy_in;
            cin = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        out_ready = 1'b1; data_rdy_in = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
